rom_load_sequencer: RTL and testbench

// - Owns the HPS ioctl download port and the core reset for the Mario Bros core.
// - Decodes index-0 ROM downloads into per-region write strobes with region-relative addresses.
// - Captures the DIP byte from index 254.
// - Holds the game core in reset while loading, then for a settle period after loading.
// - Sits between hps_io and mario_top; replaces the ad-hoc dn_wr/sw[] logic in emu.

---
 rtl/mario_pkg.sv | 19 +
 rtl/rom_region_decode.sv | 32 +++
 rtl/rom_load_sequencer.sv | 139 +++++++++++++
 tb/tb_rom_load_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared types and ROM memory map for the Mario Bros download sequencer.
// Region order: main CPU, sound CPU, tiles, sprites, PROMs.
package mario_pkg;

  localparam int NREG = 5;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {HOLD, LOAD, SETTLE, RUN} ld_state_t;

  localparam logic [24:0] REGION_BASE [NREG] = '{25'h0000, 25'h8000, 25'h9000, 25'hB000, 25'hD000};
  localparam logic [24:0] REGION_SIZE [NREG] = '{25'h8000, 25'h1000, 25'h2000, 25'h2000, 25'h0200};

  function automatic logic in_region(input logic [24:0] addr, input int k);
    return (addr >= REGION_BASE[k]) && (addr < REGION_BASE[k] + REGION_SIZE[k]);
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ioctl address decoder: one-hot region hit, region-relative
// address and a miss flag for addresses outside every region.
module rom_region_decode
  import mario_pkg::*;
(
  input  logic [24:0]     i_addr,
  output logic [NREG-1:0] o_hit,
  output logic [15:0]     o_rel_addr,
  output logic            o_miss
);

  logic [15:0] w_rel [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      assign o_hit[gi] = in_region(i_addr, gi);
      assign w_rel[gi] = o_hit[gi] ? 16'(i_addr - REGION_BASE[gi]) : 16'h0000;
    end
  endgenerate

  // Regions never overlap, so at most one term is non-zero.
  always_comb begin
    o_rel_addr = 16'h0000;
    for (int k = 0; k < NREG; k++) begin
      o_rel_addr = o_rel_addr | w_rel[k];
    end
  end

  assign o_miss = ~|o_hit;

endmodule

// File: rtl/rom_load_sequencer.sv
// Owns the hps_io download port: ROM write strobes, DIP capture and the
// game core reset sequencing (HOLD -> LOAD -> SETTLE -> RUN).
module rom_load_sequencer
  import mario_pkg::*;
#(
  parameter int          SETTLE_CYC  = 1024,
  parameter logic [15:0] MIN_BYTES   = 16'hD200,
  parameter logic [7:0]  DIP_DEFAULT = 8'h00
) (
  input  logic            I_CLK_24M,
  input  logic            I_RESETn,
  input  logic            I_DN_DOWNLOAD,
  input  logic            I_DN_WR,
  input  logic [7:0]      I_DN_INDEX,
  input  logic [24:0]     I_DN_ADDR,
  input  logic [7:0]      I_DN_DATA,
  input  logic            I_USER_RST,
  output logic            O_CORE_RESETn,
  output logic [NREG-1:0] O_ROM_WE,
  output logic [15:0]     O_ROM_ADDR,
  output logic [7:0]      O_ROM_DATA,
  output logic [7:0]      O_DIPSW,
  output logic            O_DL_ERR
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  ld_state_t       r_state;
  logic            r_dl_q;
  logic [15:0]     r_byte_cnt;
  logic [CW-1:0]   r_settle_cnt;
  logic            r_core_resetn;
  logic [NREG-1:0] r_rom_we;
  logic [15:0]     r_rom_addr;
  logic [7:0]      r_rom_data;
  logic [7:0]      r_dipsw;
  logic            r_dl_err;

  logic [NREG-1:0] w_hit;
  logic [15:0]     w_rel_addr;
  logic [15:0]     w_cnt_eff;
  logic            w_miss;
  logic            w_rom_start;
  logic            w_dl_fall;
  logic            w_rom_wr;
  logic            w_dip_wr;

  rom_region_decode u_decode (
    .i_addr     (I_DN_ADDR),
    .o_hit      (w_hit),
    .o_rel_addr (w_rel_addr),
    .o_miss     (w_miss)
  );

  assign w_rom_start = I_DN_DOWNLOAD & ~r_dl_q & (I_DN_INDEX == IDX_ROM);
  assign w_dl_fall   = ~I_DN_DOWNLOAD & r_dl_q;
  assign w_rom_wr    = (r_state == LOAD) & I_DN_WR & (I_DN_INDEX == IDX_ROM);
  assign w_dip_wr    = I_DN_WR & (I_DN_INDEX == IDX_DIP) & (I_DN_ADDR == 25'd0);

  // Count including a byte landing on the same cycle as the download end.
  assign w_cnt_eff = (w_rom_wr && (r_byte_cnt != 16'hFFFF)) ? r_byte_cnt + 16'd1 : r_byte_cnt;

  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_state       <= HOLD;
      r_dl_q        <= 1'b0;
      r_byte_cnt    <= 16'h0000;
      r_settle_cnt  <= '0;
      r_core_resetn <= 1'b0;
      r_rom_we      <= '0;
      r_rom_addr    <= 16'h0000;
      r_rom_data    <= 8'h00;
      r_dipsw       <= DIP_DEFAULT;
      r_dl_err      <= 1'b0;
    end else begin
      r_dl_q   <= I_DN_DOWNLOAD;
      r_rom_we <= '0;

      if (w_rom_wr) begin
        r_byte_cnt <= w_cnt_eff;
        r_rom_we   <= w_hit;
        r_rom_addr <= w_rel_addr;
        r_rom_data <= I_DN_DATA;
        if (w_miss) r_dl_err <= 1'b1;
      end

      if (w_dip_wr) r_dipsw <= I_DN_DATA;

      if (w_rom_start) begin
        r_state       <= LOAD;
        r_byte_cnt    <= 16'h0000;
        r_settle_cnt  <= '0;
        r_dl_err      <= 1'b0;
        r_core_resetn <= 1'b0;
      end else begin
        case (r_state)
          HOLD: ;
          LOAD: begin
            if (w_dl_fall) begin
              if (w_cnt_eff >= MIN_BYTES) begin
                r_state      <= SETTLE;
                r_settle_cnt <= '0;
              end else begin
                r_state  <= HOLD;
                r_dl_err <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (I_USER_RST) begin
              r_settle_cnt <= '0;
            end else if (r_settle_cnt == CW'(SETTLE_CYC - 1)) begin
              r_state       <= RUN;
              r_core_resetn <= 1'b1;
            end else begin
              r_settle_cnt <= r_settle_cnt + CW'(1);
            end
          end
          RUN: begin
            if (I_USER_RST) begin
              r_state       <= SETTLE;
              r_settle_cnt  <= '0;
              r_core_resetn <= 1'b0;
            end
          end
          default: r_state <= HOLD;
        endcase
      end
    end
  end

  assign O_CORE_RESETn = r_core_resetn;
  assign O_ROM_WE      = r_rom_we;
  assign O_ROM_ADDR    = r_rom_addr;
  assign O_ROM_DATA    = r_rom_data;
  assign O_DIPSW       = r_dipsw;
  assign O_DL_ERR      = r_dl_err;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer: address-map vectors, random
// download bursts against a memory-map model, and reset/settle sequences.
module tb_rom_load_sequencer;

  localparam logic [15:0] MIN = 16'h0800;  // small threshold keeps each complete load short
  localparam int SETTLE = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl, wr, user_rst;
  logic [7:0]  idx, data;
  logic [24:0] addr;
  logic        core_resetn, dl_err;
  logic [4:0]  rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, dipsw;

  int total = 0;
  int bad   = 0;
  bit exp_err;

  int unsigned rb [5] = '{32'h0000, 32'h8000, 32'h9000, 32'hB000, 32'hD000};
  int unsigned rs [5] = '{32'h8000, 32'h1000, 32'h2000, 32'h2000, 32'h0200};

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    logic [4:0]  we;
    logic [15:0] ra;
  } rom_vec_t;

  typedef struct {
    logic [7:0]  ix;
    logic [24:0] a;
    logic [7:0]  d;
    logic [7:0]  dip;
  } dip_vec_t;

  rom_vec_t rvec [10];
  dip_vec_t dvec [8];

  always #5 clk = ~clk;

  rom_load_sequencer #(.SETTLE_CYC(SETTLE), .MIN_BYTES(MIN), .DIP_DEFAULT(8'h00)) dut (
    .I_CLK_24M     (clk),
    .I_RESETn      (rst_n),
    .I_DN_DOWNLOAD (dl),
    .I_DN_WR       (wr),
    .I_DN_INDEX    (idx),
    .I_DN_ADDR     (addr),
    .I_DN_DATA     (data),
    .I_USER_RST    (user_rst),
    .O_CORE_RESETn (core_resetn),
    .O_ROM_WE      (rom_we),
    .O_ROM_ADDR    (rom_addr),
    .O_ROM_DATA    (rom_data),
    .O_DIPSW       (dipsw),
    .O_DL_ERR      (dl_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int region_of(input logic [24:0] a);
    for (int k = 0; k < 5; k++)
      if (32'(a) >= rb[k] && 32'(a) < rb[k] + rs[k]) return k;
    return -1;
  endfunction

  function automatic logic [24:0] rand_in_map();
    int k;
    k = $urandom_range(0, 4);
    return 25'(rb[k] + $urandom_range(0, rs[k] - 1));
  endfunction

  // Core reset must sit at one level for n cycles; reported as one comparison.
  task automatic hold_check(input int n, input logic exp, input string name);
    int badc, first;
    badc = 0; first = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (core_resetn !== exp) begin
        if (badc == 0) first = i;
        badc++;
      end
    end
    total++;
    if (badc != 0) begin
      bad++;
      $display("FAIL %s: core_resetn wrong on %0d cycles (first at %0d), want %b", name, badc, first, exp);
    end
  endtask

  // Cycles from the current negedge until the core leaves reset, bounded.
  task automatic measure_release(input int exp, input string name);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (core_resetn !== 1'b1 && cnt < 3000);
    chk(name, cnt, exp);
    $display("txn %s: core released after %0d cycles", name, cnt);
  endtask

  task automatic start_load(input string name);
    @(negedge clk);
    wr = 1'b0; idx = 8'd0; dl = 1'b1;
    @(negedge clk);
    exp_err = 1'b0;
    chk({name, "_err_clr"}, dl_err, 1'b0);
    chk({name, "_core_rst"}, core_resetn, 1'b0);
    $display("txn %s: download started", name);
  endtask

  // Back-to-back index-0 bytes; each strobe is checked one cycle after its write.
  task automatic rom_bytes(input int n, input int miss_at, input bit fall_last, input string name);
    int mism, k;
    string first;
    bit have;
    logic [24:0] pa;
    logic [7:0]  pd;
    logic [4:0]  ewe;
    logic [15:0] ea;
    mism = 0; first = ""; have = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (have) begin
        k = region_of(pa);
        ewe = (k < 0) ? 5'b0 : 5'(1 << k);
        ea  = (k < 0) ? 16'h0 : 16'(32'(pa) - rb[k]);
        if (k < 0) exp_err = 1'b1;
        if (rom_we !== ewe || dl_err !== exp_err ||
            (k >= 0 && (rom_addr !== ea || rom_data !== pd))) begin
          if (mism == 0)
            first = $sformatf("addr=%h we=%b/%b radr=%h/%h data=%h/%h err=%b/%b",
                              pa, rom_we, ewe, rom_addr, ea, rom_data, pd, dl_err, exp_err);
          mism++;
        end
      end
      if (i < n) begin
        pa = (i == miss_at) ? 25'hE000 : rand_in_map();
        pd = 8'($urandom);
        idx = 8'd0; addr = pa; data = pd; wr = 1'b1; have = 1'b1;
        if (fall_last && i == n - 1) dl = 1'b0;
      end else begin
        wr = 1'b0;
      end
    end
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL %s: %0d bad bytes, first %s (got/want)", name, mism, first);
    end
    $display("txn %s: %0d bytes written", name, n);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rvec[0] = '{25'h00000, 8'h11, 5'b00001, 16'h0000};
    rvec[1] = '{25'h07FFF, 8'h22, 5'b00001, 16'h7FFF};
    rvec[2] = '{25'h08000, 8'h33, 5'b00010, 16'h0000};
    rvec[3] = '{25'h08FFF, 8'h44, 5'b00010, 16'h0FFF};
    rvec[4] = '{25'h09005, 8'h55, 5'b00100, 16'h0005};
    rvec[5] = '{25'h0AFFF, 8'h66, 5'b00100, 16'h1FFF};
    rvec[6] = '{25'h0B000, 8'h77, 5'b01000, 16'h0000};
    rvec[7] = '{25'h0CFFF, 8'h88, 5'b01000, 16'h1FFF};
    rvec[8] = '{25'h0D000, 8'h99, 5'b10000, 16'h0000};
    rvec[9] = '{25'h0D1FF, 8'hAA, 5'b10000, 16'h01FF};

    dvec[0] = '{8'd254, 25'h0000000, 8'h5A, 8'h5A};
    dvec[1] = '{8'd254, 25'h0000003, 8'h77, 8'h5A};
    dvec[2] = '{8'd254, 25'h0000008, 8'h11, 8'h5A};
    dvec[3] = '{8'd7,   25'h0000000, 8'h22, 8'h5A};
    dvec[4] = '{8'd0,   25'h0000000, 8'h33, 8'h5A};
    dvec[5] = '{8'd254, 25'h1000000, 8'h44, 8'h5A};
    dvec[6] = '{8'd254, 25'h0000000, 8'hC3, 8'hC3};
    dvec[7] = '{8'd254, 25'h0000000, 8'h5A, 8'h5A};

    rst_n = 1'b0; dl = 1'b0; wr = 1'b0; user_rst = 1'b0;
    idx = 8'd0; addr = '0; data = 8'h00; exp_err = 1'b0;

    // Reset values and idle HOLD
    repeat (3) @(negedge clk);
    chk("rst_core_resetn", core_resetn, 1'b0);
    chk("rst_we", rom_we, 5'b0);
    chk("rst_addr", rom_addr, 16'h0);
    chk("rst_data", rom_data, 8'h0);
    chk("rst_dipsw", dipsw, 8'h00);
    chk("rst_err", dl_err, 1'b0);
    rst_n = 1'b1;
    hold_check(2000, 1'b0, "idle_hold");
    chk("idle_dipsw", dipsw, 8'h00);

    // DIP byte accepted while held in HOLD
    idx = 8'd254; addr = '0; data = 8'h96; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; idx = 8'd0;
    chk("dip_in_hold", dipsw, 8'h96);
    hold_check(4, 1'b0, "dip_hold_core");

    // Short load: error, stays in HOLD even across a user reset
    start_load("short");
    rom_bytes(256, -1, 1'b0, "short_bytes");
    @(negedge clk); dl = 1'b0;
    @(negedge clk);
    chk("short_err", dl_err, 1'b1);
    user_rst = 1'b1;
    hold_check(5, 1'b0, "short_usr_hi");
    user_rst = 1'b0;
    hold_check(1200, 1'b0, "short_hold");
    chk("short_err_sticky", dl_err, 1'b1);

    // Valid load: map vectors then random bytes to exactly MIN
    start_load("valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idx = 8'd0; addr = rvec[i].a; data = rvec[i].d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      chk($sformatf("vec%0d_we", i), rom_we, rvec[i].we);
      chk($sformatf("vec%0d_addr", i), rom_addr, rvec[i].ra);
      chk($sformatf("vec%0d_data", i), rom_data, rvec[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_we_1cyc", i), rom_we, 5'b0);
    end
    rom_bytes(int'(MIN) - 10, -1, 1'b0, "valid_bytes");
    @(negedge clk); dl = 1'b0;
    measure_release(1 + SETTLE, "valid_settle");
    chk("valid_err", dl_err, 1'b0);

    // RUN: DIP and ignored writes
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idx = dvec[i].ix; addr = dvec[i].a; data = dvec[i].d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      chk($sformatf("dip%0d_val", i), dipsw, dvec[i].dip);
      chk($sformatf("dip%0d_we", i), rom_we, 5'b0);
      chk($sformatf("dip%0d_core", i), core_resetn, 1'b1);
    end
    begin
      int stray;
      stray = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        idx = 8'($urandom_range(1, 253)); addr = 25'($urandom); data = 8'($urandom); wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        if (rom_we !== 5'b0 || dipsw !== 8'h5A || core_resetn !== 1'b1 || dl_err !== 1'b0) stray++;
      end
      chk("other_index_ignored", stray, 0);
      idx = 8'd0;
    end
    $display("txn run_writes: dipsw=%h", dipsw);

    // User reset pulse of 3 cycles
    @(negedge clk); user_rst = 1'b1;
    @(negedge clk);
    chk("usr_enter_settle", core_resetn, 1'b0);
    @(negedge clk);
    @(negedge clk); user_rst = 1'b0;
    measure_release(SETTLE, "usr_settle");

    // One byte short of the threshold
    start_load("min_m1");
    rom_bytes(int'(MIN) - 1, -1, 1'b0, "min_m1_bytes");
    @(negedge clk); dl = 1'b0;
    @(negedge clk);
    chk("min_m1_err", dl_err, 1'b1);
    hold_check(1200, 1'b0, "min_m1_hold");

    // Out-of-map byte counted toward MIN; restart mid-SETTLE
    start_load("miss");
    rom_bytes(int'(MIN), int'(MIN) / 2, 1'b0, "miss_bytes");
    chk("miss_err", dl_err, 1'b1);
    @(negedge clk); dl = 1'b0;
    hold_check(501, 1'b0, "miss_settle_part");
    chk("miss_err_sticky", dl_err, 1'b1);
    start_load("restart");
    rom_bytes(int'(MIN), -1, 1'b1, "restart_bytes");
    measure_release(SETTLE, "restart_settle");
    chk("restart_err", dl_err, 1'b0);

    // Asynchronous reset mid-download
    start_load("abort");
    rom_bytes(50, -1, 1'b0, "abort_bytes");
    @(negedge clk);
    idx = 8'd0; addr = 25'h0100; data = 8'hE7; wr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_core", core_resetn, 1'b0);
    chk("abort_we", rom_we, 5'b0);
    chk("abort_addr", rom_addr, 16'h0);
    chk("abort_data", rom_data, 8'h0);
    chk("abort_dipsw", dipsw, 8'h00);
    chk("abort_err", dl_err, 1'b0);
    wr = 1'b0; dl = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold_check(1500, 1'b0, "abort_hold");
    $display("txn abort: core held after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
